draw_circle_multi: RTL and testbench
====================================

// Module: draw_circle_multi
// PURPOSE
//  Parametrised N-object circle renderer in the VGA overlay chain. Draws up to N_CIRC filled or ring
//  circles over rgb_in, each with its own position, radius and colour. Object parameters are staged
//  and committed only at frame start, so puck/mallet moves never tear mid-frame.
//  Fixed 3-cycle pipeline; all timing signals are delayed to match.
// PARAMETERS
//  N_CIRC   2   number of circle objects (1..8); index 0 has highest draw priority
//  RAD_W    8   radius width in bits (radius 0..2^RAD_W-1)
//  RING_W   3   outline thickness in pixels for objects in ring mode
// PORTS
//  clk_in      in   1            pixel clock
//  rst         in   1            synchronous, active-high reset
//  hcount_in   in   12           horizontal pixel count
//  hsync_in    in   1            hsync
//  hblnk_in    in   1            hblank
//  vcount_in   in   12           vertical line count
//  vsync_in    in   1            vsync
//  vblnk_in    in   1            vblank; rising edge = frame commit point
//  rgb_in      in   12           background pixel
//  xpos_bus    in   12*N_CIRC    centre x per object, object i at [12*i +: 12]
//  ypos_bus    in   12*N_CIRC    centre y per object
//  rad_bus     in   RAD_W*N_CIRC radius per object
//  color_bus   in   12*N_CIRC    fill colour per object
//  ring_mask   in   N_CIRC       1 = ring (outline) mode, 0 = filled
//  en_mask     in   N_CIRC       1 = object drawn
//  upd_valid   in   1            staging request; samples all object buses above
//  upd_ready   out  1            1 = staging accepted (no commit pending)
//  upd_done    out  1            1-cycle pulse when staged set becomes active
//  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out
//              out  as inputs    inputs delayed by 3 cycles, rgb composited
// BEHAVIOUR
//  Reset: all outputs 0 except upd_ready=1; active and staged object sets cleared (all disabled).
//  Update FSM: IDLE -> PEND -> IDLE.
//   IDLE: upd_ready=1; upd_valid=1 -> stage all object buses, go PEND.
//   PEND: upd_ready=0, upd_valid ignored; on vblnk_in 0->1 (prev-cycle register) copy
//   staged -> active, pulse upd_done next cycle, go IDLE.
//   upd_valid in same cycle as a vblnk edge while IDLE: stage now, commit at next frame edge.
//   Reset mid-PEND: staged set discarded, no upd_done.
//  Pipeline (per active object i, all in parallel):
//   S1: dx = hcount_in - x_i, dy = vcount_in - y_i as 13-bit signed (no unsigned wrap).
//   S2: d2 = dx*dx + dy*dy, 26-bit unsigned; r2 = r_i^2; ri2 = (r_i-RING_W)^2 when r_i>RING_W, else 0.
//   S3: hit_i = en_i & (r_i!=0) & (d2<=r2) & (!ring_i | r_i<=RING_W | d2>ri2).
//  rgb_out = color of lowest-index hit object, else rgb_in delayed 3 cycles.
//  Radius 0 draws nothing. Circles clipped at screen edges/coordinate 0 draw correctly (signed).
//  Latency exactly 3 clk_in for every output; one pixel per clock, no stalls.
//  Active set is constant between commits regardless of bus activity.
// STRUCTURE
//  Package draw_pkg: COORD_W=12, RGB_W=12, PIPE_LAT=3, update FSM state enum.
//  Sub-module circle_hit (one per object, generate loop): S1-S3 distance/ring test -> hit bit.
//  Top: update FSM, staged/active registers, timing delay line, priority mux.
// TESTING
//  1 Reset then idle stream: rgb_out == rgb_in delayed 3, upd_ready=1, all timing delayed 3.
//  2 Obj0 (x=100,y=100,r=20,fill,red 12'hF00) committed: pixel (100,120) red, (100,121) background.
//  3 Ring obj0 r=20 RING_W=3: (100,118) red, (100,117) background, (100,100) background.
//  4 Obj0 blue + obj1 green both covering (50,50): output blue; disable obj0 -> green.
//  5 upd_valid mid-frame: old set drawn until vblnk rise; upd_done 1 pulse; upd_ready low meanwhile.
//  6 Obj at x=5,y=5,r=10: pixel (0,0) coloured (no wrap); r=0 draws nothing; rst during PEND -> no upd_done.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants, update-FSM state encoding and the VGA timing bundle
// for the multi-circle overlay renderer.
// Latency/backpressure: n/a (types and constants only).
package draw_pkg;

  localparam int COORD_W  = 12;
  localparam int RGB_W    = 12;
  localparam int PIPE_LAT = 3;

  typedef enum logic {
    UPD_IDLE = 1'b0,
    UPD_PEND = 1'b1
  } upd_state_t;

  // One pixel's worth of timing plus background colour, carried down the
  // delay line so every output leaves with the same latency.
  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [COORD_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_t;

endpackage

// File: rtl/circle_hit.sv
// Per-object circle/ring membership test for the current pixel -> hit bit.
// Latency: 3 clk_in (S1 offsets, S2 squared distance, S3 compare).
// Backpressure: none, one pixel per clock.
// Ports: clk_in/rst; hcount/vcount pixel position; x/y/rad/ring/en object
//        parameters (from the active set); hit registered result.
module circle_hit
  import draw_pkg::*;
#(
  parameter int RAD_W  = 8,
  parameter int RING_W = 3
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [RAD_W-1:0]   rad,
  input  logic               ring,
  input  logic               en,
  output logic               hit
);

  localparam int DW = COORD_W + 1;   // signed offset width
  localparam int SW = 2 * DW;        // squared distance width
  localparam logic [RAD_W-1:0] RING_R = RAD_W'(RING_W);

  // S1: signed offsets; zero-extend before subtracting so left/top clipping works
  logic signed [DW-1:0] dx_c, dy_c;
  logic signed [DW-1:0] dx_s1, dy_s1;
  logic [RAD_W-1:0]     rad_s1;
  logic                 ring_s1, en_s1;

  assign dx_c = $signed({1'b0, hcount}) - $signed({1'b0, x});
  assign dy_c = $signed({1'b0, vcount}) - $signed({1'b0, y});

  always_ff @(posedge clk_in) begin
    if (rst) begin
      dx_s1   <= '0;
      dy_s1   <= '0;
      rad_s1  <= '0;
      ring_s1 <= 1'b0;
      en_s1   <= 1'b0;
    end else begin
      dx_s1   <= dx_c;
      dy_s1   <= dy_c;
      rad_s1  <= rad;
      ring_s1 <= ring;
      en_s1   <= en;
    end
  end

  // S2: squared distance and squared outer/inner radii
  logic signed [SW-1:0]  sq_x, sq_y;
  logic [SW-1:0]         d2_c, r2_c, ri2_c;
  logic [2*RAD_W-1:0]    r2_n, ri2_n;
  logic [RAD_W-1:0]      ri_c;
  logic                  thin_c;

  assign sq_x   = dx_s1 * dx_s1;
  assign sq_y   = dy_s1 * dy_s1;
  assign d2_c   = $unsigned(sq_x) + $unsigned(sq_y);
  assign thin_c = (rad_s1 <= RING_R);
  assign ri_c   = thin_c ? '0 : (rad_s1 - RING_R);
  assign r2_n   = rad_s1 * rad_s1;
  assign ri2_n  = ri_c * ri_c;
  assign r2_c   = SW'(r2_n);
  assign ri2_c  = SW'(ri2_n);

  logic [SW-1:0] d2_s2, r2_s2, ri2_s2;
  logic          ring_s2, en_s2, thin_s2, nz_s2;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      d2_s2   <= '0;
      r2_s2   <= '0;
      ri2_s2  <= '0;
      ring_s2 <= 1'b0;
      en_s2   <= 1'b0;
      thin_s2 <= 1'b0;
      nz_s2   <= 1'b0;
    end else begin
      d2_s2   <= d2_c;
      r2_s2   <= r2_c;
      ri2_s2  <= ri2_c;
      ring_s2 <= ring_s1;
      en_s2   <= en_s1;
      thin_s2 <= thin_c;
      nz_s2   <= (rad_s1 != '0);
    end
  end

  // S3: inside outer circle, and outside the hole unless filled or too thin for a hole
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hit <= 1'b0;
    end else begin
      hit <= en_s2 & nz_s2 & (d2_s2 <= r2_s2) &
             (~ring_s2 | thin_s2 | (d2_s2 > ri2_s2));
    end
  end

endmodule

// File: rtl/draw_circle_multi.sv
// N-object circle/ring overlay; object set staged and committed at vblank rise.
// Latency: 3 clk_in for every output, one pixel per clock, no stalls.
// Backpressure: upd_ready low while a staged set waits for the frame edge.
// Ports: clk_in/rst; VGA timing + rgb_in in, delayed copies out with rgb
//        composited; per-object buses; upd_valid/upd_ready/upd_done handshake.
module draw_circle_multi
  import draw_pkg::*;
#(
  parameter int N_CIRC = 2,
  parameter int RAD_W  = 8,
  parameter int RING_W = 3
) (
  input  logic                        clk_in,
  input  logic                        rst,
  input  logic [COORD_W-1:0]          hcount_in,
  input  logic                        hsync_in,
  input  logic                        hblnk_in,
  input  logic [COORD_W-1:0]          vcount_in,
  input  logic                        vsync_in,
  input  logic                        vblnk_in,
  input  logic [RGB_W-1:0]            rgb_in,
  input  logic [COORD_W*N_CIRC-1:0]   xpos_bus,
  input  logic [COORD_W*N_CIRC-1:0]   ypos_bus,
  input  logic [RAD_W*N_CIRC-1:0]     rad_bus,
  input  logic [RGB_W*N_CIRC-1:0]     color_bus,
  input  logic [N_CIRC-1:0]           ring_mask,
  input  logic [N_CIRC-1:0]           en_mask,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  output logic                        upd_done,
  output logic [COORD_W-1:0]          hcount_out,
  output logic                        hsync_out,
  output logic                        hblnk_out,
  output logic [COORD_W-1:0]          vcount_out,
  output logic                        vsync_out,
  output logic                        vblnk_out,
  output logic [RGB_W-1:0]            rgb_out
);

  upd_state_t state;
  logic       vblnk_prev;
  logic       frame_edge;

  logic [COORD_W*N_CIRC-1:0] stg_x, stg_y, act_x, act_y;
  logic [RAD_W*N_CIRC-1:0]   stg_rad, act_rad;
  logic [RGB_W*N_CIRC-1:0]   stg_color, act_color;
  logic [N_CIRC-1:0]         stg_ring, stg_en, act_ring, act_en;

  assign frame_edge = vblnk_in & ~vblnk_prev;

  // Update FSM: stage on request, swap into the active set on the frame edge
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= UPD_IDLE;
      vblnk_prev <= 1'b0;
      upd_ready  <= 1'b1;
      upd_done   <= 1'b0;
      stg_x      <= '0;
      stg_y      <= '0;
      stg_rad    <= '0;
      stg_color  <= '0;
      stg_ring   <= '0;
      stg_en     <= '0;
      act_x      <= '0;
      act_y      <= '0;
      act_rad    <= '0;
      act_color  <= '0;
      act_ring   <= '0;
      act_en     <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      upd_done   <= 1'b0;
      case (state)
        UPD_IDLE: begin
          if (upd_valid) begin
            stg_x     <= xpos_bus;
            stg_y     <= ypos_bus;
            stg_rad   <= rad_bus;
            stg_color <= color_bus;
            stg_ring  <= ring_mask;
            stg_en    <= en_mask;
            state     <= UPD_PEND;
            upd_ready <= 1'b0;
          end
        end
        UPD_PEND: begin
          if (frame_edge) begin
            act_x     <= stg_x;
            act_y     <= stg_y;
            act_rad   <= stg_rad;
            act_color <= stg_color;
            act_ring  <= stg_ring;
            act_en    <= stg_en;
            upd_done  <= 1'b1;
            state     <= UPD_IDLE;
            upd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= UPD_IDLE;
          upd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Per-object hit pipelines
  logic [N_CIRC-1:0] hit;

  for (genvar i = 0; i < N_CIRC; i++) begin : g_obj
    circle_hit #(
      .RAD_W  (RAD_W),
      .RING_W (RING_W)
    ) u_hit (
      .clk_in (clk_in),
      .rst    (rst),
      .hcount (hcount_in),
      .vcount (vcount_in),
      .x      (act_x[COORD_W*i +: COORD_W]),
      .y      (act_y[COORD_W*i +: COORD_W]),
      .rad    (act_rad[RAD_W*i +: RAD_W]),
      .ring   (act_ring[i]),
      .en     (act_en[i]),
      .hit    (hit[i])
    );
  end

  // Timing/background delay line matching the hit pipeline depth
  vga_t vin;
  vga_t dly [PIPE_LAT];

  assign vin = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) dly[k] <= '0;
    end else begin
      dly[0] <= vin;
      for (int k = 1; k < PIPE_LAT; k++) dly[k] <= dly[k-1];
    end
  end

  assign hcount_out = dly[PIPE_LAT-1].hcount;
  assign hsync_out  = dly[PIPE_LAT-1].hsync;
  assign hblnk_out  = dly[PIPE_LAT-1].hblnk;
  assign vcount_out = dly[PIPE_LAT-1].vcount;
  assign vsync_out  = dly[PIPE_LAT-1].vsync;
  assign vblnk_out  = dly[PIPE_LAT-1].vblnk;

  // Priority mux: walk from highest index down so the lowest-index hit wins
  always_comb begin
    rgb_out = dly[PIPE_LAT-1].rgb;
    for (int i = N_CIRC - 1; i >= 0; i--) begin
      if (hit[i]) rgb_out = act_color[RGB_W*i +: RGB_W];
    end
  end

endmodule

// File: tb/tb_draw_circle_multi.sv
module tb_draw_circle_multi;

  localparam logic [11:0] BG    = 12'h0AB;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] BLUE  = 12'h00F;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [23:0] xpos_bus = '0, ypos_bus = '0, color_bus = '0;
  logic [15:0] rad_bus = '0;
  logic [1:0]  ring_mask = '0, en_mask = '0;
  logic        upd_valid = 1'b0;
  logic        upd_ready, upd_done;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  draw_circle_multi #(.N_CIRC(2), .RAD_W(8), .RING_W(3)) dut (
    .clk_in(clk_in), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .xpos_bus(xpos_bus), .ypos_bus(ypos_bus), .rad_bus(rad_bus),
    .color_bus(color_bus), .ring_mask(ring_mask), .en_mask(en_mask),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_done(upd_done),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Hold one pixel for the full pipeline depth and return the composited colour
  task automatic pixel(input logic [11:0] h, input logic [11:0] v, output logic [11:0] obs);
    @(posedge clk_in); #1;
    hcount_in = h;
    vcount_in = v;
    rgb_in    = BG;
    repeat (3) @(posedge clk_in);
    #1;
    obs = rgb_out;
  endtask

  // Stage an object set, then raise vblank and count upd_done pulses
  task automatic commit(input logic [23:0] xb, input logic [23:0] yb, input logic [15:0] rb,
                        input logic [23:0] cb, input logic [1:0] rm, input logic [1:0] em,
                        output logic rdy_low, output int done_cnt);
    @(posedge clk_in); #1;
    vblnk_in  = 1'b0;
    xpos_bus  = xb;
    ypos_bus  = yb;
    rad_bus   = rb;
    color_bus = cb;
    ring_mask = rm;
    en_mask   = em;
    upd_valid = 1'b1;
    @(posedge clk_in); #1;
    upd_valid = 1'b0;
    rdy_low   = (upd_ready === 1'b0);
    // scramble the buses: the active set must not follow them
    xpos_bus  = '0;
    ypos_bus  = '0;
    rad_bus   = '0;
    color_bus = 24'h123456;
    en_mask   = '0;
    vblnk_in  = 1'b1;
    done_cnt  = 0;
    repeat (6) begin
      @(posedge clk_in); #1;
      if (upd_done === 1'b1) done_cnt++;
    end
    vblnk_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hcount_in = 12'h7FF; vcount_in = 12'h3FF; rgb_in = 12'hFFF;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    total++;
    if (rgb_out !== 12'h000 || hcount_out !== 12'h000 || vcount_out !== 12'h000 ||
        hsync_out !== 1'b0 || vsync_out !== 1'b0 || hblnk_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: rgb=%h hc=%h vc=%h hs=%b vs=%b hb=%b required all zero",
               rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out);
    end
    total++;
    if (upd_ready !== 1'b1 || upd_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: ready=%b done=%b required 1 0", upd_ready, upd_done);
    end
    rst = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0;
  endtask

  task automatic test_stream;
    logic [11:0] hh [16];
    logic [11:0] vh [16];
    logic [11:0] ch [16];
    logic [2:0]  fh [16];
    for (int c = 0; c < 16; c++) begin
      @(posedge clk_in); #1;
      if (c >= 3) begin
        total++;
        if (rgb_out !== ch[c-3] || hcount_out !== hh[c-3] || vcount_out !== vh[c-3] ||
            {hsync_out, hblnk_out, vsync_out} !== fh[c-3] || vblnk_out !== 1'b0) begin
          bad++;
          $display("FAIL stream_delay[%0d]: rgb=%h hc=%h vc=%h flags=%b required rgb=%h hc=%h vc=%h flags=%b",
                   c, rgb_out, hcount_out, vcount_out, {hsync_out, hblnk_out, vsync_out},
                   ch[c-3], hh[c-3], vh[c-3], fh[c-3]);
        end
      end
      hh[c] = 12'(c * 7 + 3);
      vh[c] = 12'(c + 1);
      ch[c] = 12'(c * 37 + 5);
      fh[c] = 3'(c);
      hcount_in = hh[c];
      vcount_in = vh[c];
      rgb_in    = ch[c];
      {hsync_in, hblnk_in, vsync_in} = fh[c];
    end
    total++;
    if (upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL stream_ready: ready=%b required 1", upd_ready);
    end
    hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic test_fill;
    logic rl; int dc; logic [11:0] o;
    commit({12'd0, 12'd100}, {12'd0, 12'd100}, {8'd0, 8'd20}, {12'h000, RED}, 2'b00, 2'b01, rl, dc);
    total++;
    if (!rl || dc != 1) begin
      bad++;
      $display("FAIL fill_commit: ready_low=%b done_pulses=%0d required 1 1", rl, dc);
    end
    pixel(12'd100, 12'd120, o);
    total++;
    if (o !== RED) begin bad++; $display("FAIL fill_edge_in: got %h required %h", o, RED); end
    pixel(12'd100, 12'd121, o);
    total++;
    if (o !== BG) begin bad++; $display("FAIL fill_edge_out: got %h required %h", o, BG); end
    pixel(12'd100, 12'd100, o);
    total++;
    if (o !== RED) begin bad++; $display("FAIL fill_centre: got %h required %h", o, RED); end
  endtask

  task automatic test_ring;
    logic rl; int dc; logic [11:0] o;
    commit({12'd0, 12'd100}, {12'd0, 12'd100}, {8'd0, 8'd20}, {12'h000, RED}, 2'b01, 2'b01, rl, dc);
    total++;
    if (dc != 1) begin bad++; $display("FAIL ring_commit: done_pulses=%0d required 1", dc); end
    pixel(12'd100, 12'd118, o);
    total++;
    if (o !== RED) begin bad++; $display("FAIL ring_inner_edge: got %h required %h", o, RED); end
    pixel(12'd100, 12'd117, o);
    total++;
    if (o !== BG) begin bad++; $display("FAIL ring_hole_edge: got %h required %h", o, BG); end
    pixel(12'd100, 12'd100, o);
    total++;
    if (o !== BG) begin bad++; $display("FAIL ring_centre: got %h required %h", o, BG); end
  endtask

  task automatic test_priority;
    logic rl; int dc; logic [11:0] o;
    commit({12'd50, 12'd50}, {12'd50, 12'd50}, {8'd5, 8'd5}, {GREEN, BLUE}, 2'b00, 2'b11, rl, dc);
    pixel(12'd50, 12'd50, o);
    total++;
    if (o !== BLUE) begin bad++; $display("FAIL prio_both: got %h required %h", o, BLUE); end
    commit({12'd50, 12'd50}, {12'd50, 12'd50}, {8'd5, 8'd5}, {GREEN, BLUE}, 2'b00, 2'b10, rl, dc);
    pixel(12'd50, 12'd50, o);
    total++;
    if (o !== GREEN) begin bad++; $display("FAIL prio_obj1_only: got %h required %h", o, GREEN); end
  endtask

  task automatic test_midframe;
    logic rl; int dc; logic [11:0] o;
    commit({12'd0, 12'd100}, {12'd0, 12'd100}, {8'd0, 8'd20}, {12'h000, RED}, 2'b00, 2'b01, rl, dc);
    // stage blue while the frame is still running
    @(posedge clk_in); #1;
    xpos_bus = {12'd0, 12'd100}; ypos_bus = {12'd0, 12'd100}; rad_bus = {8'd0, 8'd20};
    color_bus = {12'h000, BLUE}; ring_mask = 2'b00; en_mask = 2'b01;
    upd_valid = 1'b1;
    @(posedge clk_in); #1;
    upd_valid = 1'b0;
    color_bus = {12'h000, GREEN};
    total++;
    if (upd_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_low: ready=%b required 0", upd_ready); end
    pixel(12'd100, 12'd100, o);
    total++;
    if (o !== RED) begin bad++; $display("FAIL mid_old_set: got %h required %h", o, RED); end
    total++;
    if (upd_ready !== 1'b0 || upd_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_still_pending: ready=%b done=%b required 0 0", upd_ready, upd_done);
    end
    vblnk_in = 1'b1;
    dc = 0;
    repeat (6) begin
      @(posedge clk_in); #1;
      if (upd_done === 1'b1) dc++;
    end
    vblnk_in = 1'b0;
    total++;
    if (dc != 1 || upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_done_pulse: pulses=%0d ready=%b required 1 1", dc, upd_ready);
    end
    pixel(12'd100, 12'd100, o);
    total++;
    if (o !== BLUE) begin bad++; $display("FAIL mid_new_set: got %h required %h", o, BLUE); end
  endtask

  task automatic test_edges;
    logic rl; int dc; logic [11:0] o;
    commit({12'd0, 12'd5}, {12'd0, 12'd5}, {8'd0, 8'd10}, {12'h000, RED}, 2'b00, 2'b01, rl, dc);
    pixel(12'd0, 12'd0, o);
    total++;
    if (o !== RED) begin bad++; $display("FAIL clip_origin: got %h required %h", o, RED); end
    pixel(12'd16, 12'd5, o);
    total++;
    if (o !== BG) begin bad++; $display("FAIL clip_outside: got %h required %h", o, BG); end
    commit({12'd0, 12'd5}, {12'd0, 12'd5}, {8'd0, 8'd0}, {12'h000, RED}, 2'b00, 2'b01, rl, dc);
    pixel(12'd5, 12'd5, o);
    total++;
    if (o !== BG) begin bad++; $display("FAIL radius_zero: got %h required %h", o, BG); end
    // reset while a commit is pending
    @(posedge clk_in); #1;
    xpos_bus = {12'd0, 12'd5}; ypos_bus = {12'd0, 12'd5}; rad_bus = {8'd0, 8'd10};
    color_bus = {12'h000, GREEN}; en_mask = 2'b01;
    upd_valid = 1'b1;
    @(posedge clk_in); #1;
    upd_valid = 1'b0;
    total++;
    if (upd_ready !== 1'b0) begin bad++; $display("FAIL rst_pend_ready: ready=%b required 0", upd_ready); end
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    total++;
    if (upd_ready !== 1'b1) begin bad++; $display("FAIL rst_pend_ready_back: ready=%b required 1", upd_ready); end
    vblnk_in = 1'b1;
    dc = 0;
    repeat (6) begin
      @(posedge clk_in); #1;
      if (upd_done === 1'b1) dc++;
    end
    vblnk_in = 1'b0;
    total++;
    if (dc != 0) begin bad++; $display("FAIL rst_pend_no_done: pulses=%0d required 0", dc); end
    pixel(12'd5, 12'd5, o);
    total++;
    if (o !== BG) begin bad++; $display("FAIL rst_pend_discarded: got %h required %h", o, BG); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_ring();
    test_priority();
    test_midframe();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
